// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rs232_pkg
// Description : Definitions shared by the RS232 transmitter and receiver.
//               - baud_count(): clocks per bit, rounded to the nearest integer
//                 so both directions derive the same bit period.
//               - rx_state_e : receiver state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

  // Clocks per bit. int'() rounds to nearest, matching integer(real).
  function automatic int baud_count(input real clock_freq, input real baud_rate);
    return int'(clock_freq / baud_rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_to_axis_if.sv
`default_nettype none
// ============================================================================
// Interface   : rs232_to_axis_if
// Description : Byte-wide AXI-stream link from the RS232 receiver to the
//               downstream consumer.
// Signals     : odata  - byte (master -> slave)
//               ovalid - byte valid (master -> slave)
//               oready - consumer ready (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs232_to_axis_if;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;

  modport master (output odata, output ovalid, input oready);
  modport slave  (input odata, input ovalid, output oready);
endinterface
`default_nettype wire

// File: rtl/axis_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_sync
// Description : Synchronous FIFO with a registered first-word-fall-through
//               AXI-stream output. DEPTH must be a power of two.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               in_data_i/valid_i/ready_o   - write side (AXI-stream)
//               out_data_o/valid_o/ready_i  - read side (AXI-stream)
//               count_o           - registered occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             pop, push, full;

  assign pop        = out_valid_q && out_ready_i;
  assign full       = (count_q == CW'(DEPTH));
  assign in_ready_o = !full || pop;
  assign push       = in_valid_i && in_ready_o;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    out_valid_d = (count_d != '0);
    // Next head word: bypass the incoming byte when it lands in the head slot
    // (push into an empty FIFO, or the pop drains to exactly the new word).
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = in_data_i;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset: a word is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/rs232_to_axis.sv
`default_nettype none
// ============================================================================
// Module      : rs232_to_axis
// Description : RS232 8N1 receiver (LSB first) with AXI-stream byte output,
//               a small receive FIFO and RTSn hardware flow control.
// Ports       : clock, reset   - clock, synchronous active-high reset
//               rxd_pin        - serial data in (remote TXD)
//               rtsn_pin       - request-to-send, active low (remote CTSn)
//               axis (master)  - odata / ovalid / oready byte stream
//               frame_error    - 1-cycle pulse, stop bit sampled 0
//               overrun_error  - 1-cycle pulse, good byte dropped (FIFO full)
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_to_axis
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rxd_pin,
  output logic            rtsn_pin,
  rs232_to_axis_if.master axis,
  output logic            frame_error,
  output logic            overrun_error
);

  localparam int BAUD_COUNT = baud_count(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int TW         = $clog2(BAUD_COUNT + 1);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] BAUD_RELOAD = TW'(BAUD_COUNT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_COUNT - 1);
  // Keep two slots free: the frame in flight plus one more the remote may
  // start before it notices CTSn going high.
  localparam logic [CW-1:0] RTS_LEVEL   = CW'(FIFO_DEPTH - 2);

  // Two-flop synchroniser on the asynchronous RXD pin.
  logic sync1_q, sync2_q;
  logic rxd_s;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_error_q, frame_error_d;
  logic          overrun_error_q, overrun_error_d;
  logic          rtsn_q;

  logic          timer_expired;
  logic          push_req;
  logic          fifo_in_ready;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;

  assign rxd_s         = sync2_q;
  assign timer_expired = (timer_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= rxd_pin;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= WAIT_HIGH;
      timer_q         <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      frame_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      frame_error_q   <= frame_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_expired ? timer_q : timer_q - TW'(1);
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    push_req        = 1'b0;
    frame_error_d   = 1'b0;
    overrun_error_d = 1'b0;

    unique case (state_q)
      // Wait for an idle (high) line so a mid-frame reset or a break is
      // never mistaken for a start bit.
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!rxd_s) begin
          timer_d = HALF_RELOAD;
          state_d = START;
        end
      end

      // Middle of the start bit: a high line here was a glitch.
      START: begin
        if (timer_expired) begin
          if (!rxd_s) begin
            timer_d   = BAUD_RELOAD;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (timer_expired) begin
          shift_d   = {rxd_s, shift_q[7:1]};
          timer_d   = BAUD_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      // Middle of the stop bit. Going back to IDLE here rather than at the
      // end of the bit leaves half a bit of slack for back-to-back frames.
      STOP: begin
        if (timer_expired) begin
          if (rxd_s) begin
            if (fifo_in_ready) begin
              push_req = 1'b1;
            end else begin
              overrun_error_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end
      end

      default: begin
        state_d = WAIT_HIGH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive buffer
  // --------------------------------------------------------------------------
  axis_fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_data_i   (shift_q),
    .in_valid_i  (push_req),
    .in_ready_o  (fifo_in_ready),
    .out_data_o  (axis.odata),
    .out_valid_o (axis.ovalid),
    .out_ready_i (axis.oready),
    .count_o     (fifo_count)
  );

  // push_req is only raised when the FIFO can accept, so it is the push.
  assign pop = axis.ovalid && axis.oready;

  always_comb begin
    count_next = fifo_count;
    if (push_req && !pop) begin
      count_next = fifo_count + CW'(1);
    end else if (!push_req && pop) begin
      count_next = fifo_count - CW'(1);
    end
  end

  // Flow control looks at the occupancy after this cycle's transfers so
  // RTSn reacts in the same cycle the count changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      rtsn_q <= 1'b1;
    end else begin
      rtsn_q <= (count_next >= RTS_LEVEL);
    end
  end

  assign rtsn_pin      = rtsn_q;
  assign frame_error   = frame_error_q;
  assign overrun_error = overrun_error_q;

endmodule
`default_nettype wire

// File: tb/tb_rs232_to_axis.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_to_axis
// Description : Scoreboard bench for rs232_to_axis at CLOCK_FREQ=16,
//               BAUD_RATE=1 (16 clocks per bit), FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_to_axis;
  import rs232_pkg::*;

  localparam int BIT   = 16;
  localparam int DEPTH = 4;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic rxd_pin = 1'b1;
  logic rtsn_pin, frame_error, overrun_error;

  rs232_to_axis_if axis ();

  rs232_to_axis #(
    .CLOCK_FREQ (16.0),
    .BAUD_RATE  (1.0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rxd_pin       (rxd_pin),
    .rtsn_pin      (rtsn_pin),
    .axis          (axis),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes the receiver should deliver, in order,
  // plus the error pulses it should have produced.
  logic [7:0] exp_q[$];
  int exp_beats = 0, exp_ferr = 0, exp_ovr = 0;
  int beats = 0, ferr_seen = 0, ovr_seen = 0;
  int start_cyc = 0, last_beat_cyc = 0;
  bit rnd_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_error)   ferr_seen++;
      if (overrun_error) ovr_seen++;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, axis.ovalid}, 32'd1);
        chk("stall_data", {24'd0, axis.odata}, {24'd0, prev_data});
      end
      if (axis.ovalid && axis.oready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", axis.odata);
        end else begin
          chk("data", {24'd0, axis.odata}, {24'd0, exp_q.pop_front()});
        end
        beats++;
        last_beat_cyc = cyc;
      end
      prev_stall = axis.ovalid && !axis.oready;
      prev_data  = axis.odata;
    end
  end

  // Drive one 8N1 frame. The model decision is made at the start: a good
  // frame is delivered if the receiver has room, otherwise it is an overrun.
  task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit scored);
    if (scored) begin
      if (!good_stop) begin
        exp_ferr++;
      end else if (exp_q.size() < DEPTH) begin
        exp_q.push_back(b);
        exp_beats++;
      end else begin
        exp_ovr++;
      end
    end
    @(posedge clock);
    #1;
    start_cyc = cyc;
    rxd_pin   = 1'b0;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rxd_pin = b[i];
      repeat (BIT) @(posedge clock);
    end
    #1 rxd_pin = good_stop;
    repeat (good_stop ? BIT : 2 * BIT) @(posedge clock);
    if (!good_stop) begin
      #1 rxd_pin = 1'b1;
      repeat (BIT) @(posedge clock);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clock);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    axis.oready = 1'b1;
    // ---- reset values ----
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rtsn",   {31'd0, rtsn_pin},      32'd1);
    chk("rst_ovalid", {31'd0, axis.ovalid},   32'd0);
    chk("rst_odata",  {24'd0, axis.odata},    32'd0);
    chk("rst_ferr",   {31'd0, frame_error},   32'd0);
    chk("rst_ovr",    {31'd0, overrun_error}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 chk("rts_after_reset", {31'd0, rtsn_pin}, 32'd0);
    repeat (4) @(posedge clock);

    // ---- 0x55, latency 9.5 bit-times + 3 clocks ----
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk("latency", last_beat_cyc - start_cyc, 9 * BIT + BIT / 2 + 3);
    chk("beats_55", beats, exp_beats);
    chk("ferr_55", ferr_seen, 0);
    chk("ovr_55", ovr_seen, 0);

    // ---- start-bit glitch ----
    #1 rxd_pin = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd_pin = 1'b1;
    repeat (2 * BIT) @(posedge clock);
    #1;
    chk("glitch_state", dut.state_q, IDLE);
    chk("glitch_beats", beats, exp_beats);
    chk("glitch_ferr", ferr_seen, exp_ferr);

    // ---- frame error then recovery ----
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk("ferr_count", ferr_seen, exp_ferr);
    chk("ferr_beats", beats, exp_beats);

    // ---- overrun / flow control ----
    drain("drain_pre_ovr");
    #1 axis.oready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1);
    #1 chk("rts_after_1", {31'd0, rtsn_pin}, 32'd0);
    send_frame(8'h02, 1'b1, 1'b1);
    #1 chk("rts_after_2", {31'd0, rtsn_pin}, 32'd1);
    send_frame(8'h03, 1'b1, 1'b1);
    send_frame(8'h04, 1'b1, 1'b1);
    send_frame(8'h05, 1'b1, 1'b1);
    #1;
    chk("ovr_count", ovr_seen, exp_ovr);
    chk("ovr_rts", {31'd0, rtsn_pin}, 32'd1);
    chk("ovr_head", {24'd0, axis.odata}, 32'h01);
    axis.oready = 1'b1;
    drain("drain_ovr");
    repeat (2) @(posedge clock);
    #1 chk("rts_drained", {31'd0, rtsn_pin}, 32'd0);
    chk("ovr_beats", beats, exp_beats);

    // ---- reset in the middle of a frame, released while line is low ----
    fork
      send_frame(8'h00, 1'b1, 1'b0);
      begin
        @(posedge clock);
        repeat (3 * BIT + 2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
      end
    join
    repeat (4) @(posedge clock);
    chk("rstmid_beats", beats, exp_beats);
    chk("rstmid_ferr", ferr_seen, exp_ferr);
    send_frame(8'hF0, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk("rstmid_f0", beats, exp_beats);

    // ---- random back-to-back frames, random ready ----
    fork
      begin
        for (int n = 0; n < 16; n++) send_frame(8'($urandom), 1'b1, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1 axis.oready = 1'($urandom_range(0, 1));
        end
      end
    join
    #1 axis.oready = 1'b1;
    drain("drain_rand");
    repeat (4) @(posedge clock);
    chk("rand_beats", beats, exp_beats);
    chk("rand_ferr", ferr_seen, exp_ferr);
    chk("rand_ovr", ovr_seen, exp_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
